// File: rtl/usb_rx_pkg.sv
// Shared types for the inbound USB receive path: line-state classes, receiver FSM states
// and the default SYNC byte.
package usb_rx_pkg;

  typedef enum logic [1:0] {LS_J, LS_K, LS_SE0, LS_SE1} line_state_t;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERR} rx_state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'h80;

  // Idle on this link is SE1, not J.
  function automatic line_state_t classify(input logic dp, input logic dm);
    line_state_t ls;
    case ({dp, dm})
      2'b10:   ls = LS_J;
      2'b01:   ls = LS_K;
      2'b00:   ls = LS_SE0;
      default: ls = LS_SE1;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/usb_line_sync.sv
// D+/D- synchronizer, line-state classifier and the bit sample strobe, which re-centres
// on every line-state change.
module usb_line_sync
  import usb_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        d_plus,
  input  logic        d_minus,
  output line_state_t line_state,
  output logic        line_dp,
  output logic        strobe
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] Half = CntW'(CLKS_PER_BIT / 2);
  localparam logic [CntW-1:0] Last = CntW'(CLKS_PER_BIT - 1);

  logic [SYNC_STAGES-1:0] dp_q;
  logic [SYNC_STAGES-1:0] dm_q;
  line_state_t            ls_prev_q;
  logic [CntW-1:0]        cnt_q;
  logic [CntW-1:0]        cnt_cur;
  logic [CntW-1:0]        cnt_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_q      <= '1;
      dm_q      <= '1;
      ls_prev_q <= LS_SE1;
      cnt_q     <= '0;
    end else begin
      dp_q      <= {dp_q[SYNC_STAGES-2:0], d_plus};
      dm_q      <= {dm_q[SYNC_STAGES-2:0], d_minus};
      ls_prev_q <= line_state;
      cnt_q     <= cnt_d;
    end
  end

  assign line_dp    = dp_q[SYNC_STAGES-1];
  assign line_state = classify(dp_q[SYNC_STAGES-1], dm_q[SYNC_STAGES-1]);

  // A change restarts the bit period so the strobe lands mid-bit.
  always_comb begin
    cnt_cur = (line_state != ls_prev_q) ? '0 : cnt_q;
    strobe  = (cnt_cur == Half);
    cnt_d   = (cnt_cur == Last) ? '0 : cnt_cur + CntW'(1);
  end

endmodule

// File: rtl/usb_receive_in.sv
// Inbound USB receiver: level-change bit decode, SYNC check, LSB-first byte assembly,
// EOP and line-error flagging.
module usb_receive_in
  import usb_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter logic [7:0]  SYNC_PATTERN = SYNC_DEFAULT
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus,
  input  logic       d_minus,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_active,
  output logic       rx_eop,
  output logic       rx_error
);

  line_state_t line_state;
  logic        line_dp;
  logic        strobe;

  rx_state_t   state_q;
  logic        prev_level_q;
  logic [2:0]  bitcnt_q;
  logic [6:0]  shreg_q;

  logic        line_is_data;
  logic        rx_bit;
  logic [7:0]  byte_nxt;

  usb_line_sync #(
    .SYNC_STAGES  (SYNC_STAGES),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_line_sync (
    .clk        (clk),
    .n_rst      (n_rst),
    .d_plus     (d_plus),
    .d_minus    (d_minus),
    .line_state (line_state),
    .line_dp    (line_dp),
    .strobe     (strobe)
  );

  // shreg_q holds the seven earlier bits; the current bit completes the byte.
  always_comb begin
    line_is_data = (line_state == LS_J) || (line_state == LS_K);
    rx_bit       = (line_dp != prev_level_q);
    byte_nxt     = {rx_bit, shreg_q};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      prev_level_q  <= 1'b1;
      bitcnt_q      <= 3'd0;
      shreg_q       <= 7'h00;
      rx_data       <= 8'h00;
      rx_data_valid <= 1'b0;
      rx_active     <= 1'b0;
      rx_eop        <= 1'b0;
      rx_error      <= 1'b0;
    end else begin
      rx_data_valid <= 1'b0;
      rx_eop        <= 1'b0;
      rx_error      <= 1'b0;
      if (strobe) begin
        case (state_q)
          IDLE: begin
            // First bit is always decoded against an implied previous level of J.
            if (line_is_data) begin
              state_q      <= SYNC;
              prev_level_q <= line_dp;
              shreg_q      <= {~line_dp, 6'h00};
              bitcnt_q     <= 3'd1;
            end
          end
          SYNC: begin
            if (line_is_data) begin
              prev_level_q <= line_dp;
              shreg_q      <= byte_nxt[7:1];
              if (bitcnt_q == 3'd7) begin
                bitcnt_q <= 3'd0;
                if (byte_nxt == SYNC_PATTERN) begin
                  state_q   <= DATA;
                  rx_active <= 1'b1;
                end else begin
                  state_q  <= ERR;
                  rx_error <= 1'b1;
                end
              end else begin
                bitcnt_q <= bitcnt_q + 3'd1;
              end
            end else begin
              state_q  <= ERR;
              rx_error <= 1'b1;
            end
          end
          DATA: begin
            if (line_is_data) begin
              prev_level_q <= line_dp;
              shreg_q      <= byte_nxt[7:1];
              bitcnt_q     <= bitcnt_q + 3'd1;
              if (bitcnt_q == 3'd7) begin
                rx_data       <= byte_nxt;
                rx_data_valid <= 1'b1;
              end
            end else if (line_state == LS_SE0) begin
              // A partial byte at EOP is reported alongside the EOP itself.
              state_q   <= EOP;
              rx_active <= 1'b0;
              rx_eop    <= 1'b1;
              rx_error  <= (bitcnt_q != 3'd0);
            end else begin
              state_q   <= ERR;
              rx_active <= 1'b0;
              rx_error  <= 1'b1;
            end
          end
          EOP: begin
            if (line_state == LS_SE1) begin
              state_q <= IDLE;
            end else if (line_is_data) begin
              state_q <= ERR;
            end
          end
          ERR: begin
            if (line_state == LS_SE1) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
